// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM state
// encoding, grant-owner codes and the full-word byte-enable value.
package mem_arb_pkg;

   // Arbiter FSM states (2-bit encoding)
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT  = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Current owner of the memory port
   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IF   = 2'b01;
   localparam logic [1:0] OWN_D    = 2'b10;

   // Fetches always read a whole word
   localparam logic [3:0] BE_FULL  = 4'hF;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation guard for the instruction-fetch port: counts consecutive data
// grants made while a fetch was waiting and raises force_if once the count
// reaches STARVE_MAX, so the next arbitration goes to IF.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic d_grant,
   input  logic if_grant,
   input  logic if_req,
   output logic force_if
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] cnt;

   // Count D grants that bypassed a waiting fetch; any IF grant or an
   // uncontested D grant restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (if_grant) begin
         cnt <= '0;
      end else if (d_grant) begin
         if (!if_req)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   assign force_if = if_req && (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and the
// MEM stage (D). One transaction at a time: IDLE -> GNT -> RESP -> IDLE.
// D has priority over IF. Defining ARB_STARVE_GUARD_EN adds a starvation
// guard that forces an IF grant after STARVE_MAX contested D grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   // data port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   // memory side
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   // pipeline hazard interface
   output logic              stall_if,
   output logic              stall_mem,
   output logic [1:0]        gnt_owner
);

   state_t            state, state_nxt;
   logic              mem_req_nxt, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   logic [3:0]        mem_be_nxt;
   logic [1:0]        gnt_owner_nxt;
   logic [DATA_W-1:0] if_rdata_nxt, d_rdata_nxt;
   logic              if_ack_nxt, d_ack_nxt;

   logic              force_if;
   logic              pick_d;
   logic              pick_if;

   // Arbitration decision used in IDLE: D first unless the guard forces IF
   assign pick_d  = d_req & ~force_if;
   assign pick_if = if_req & ~pick_d;

`ifdef ARB_STARVE_GUARD_EN
   mem_arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk      (clk),
      .rst      (rst),
      .d_grant  ((state == ST_IDLE) && pick_d),
      .if_grant ((state == ST_IDLE) && pick_if),
      .if_req   (if_req),
      .force_if (force_if)
   );
`else
   // Strict D priority: IF is never forced ahead of a data request
   assign force_if = 1'b0;
`endif

   // Stall a stage for as long as its request is outstanding
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = d_req & ~d_ack;

   // Next-state and next-output logic of the arbiter FSM
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_nxt     = state;
      mem_req_nxt   = mem_req;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_be_nxt    = mem_be;
      gnt_owner_nxt = gnt_owner;
      if_rdata_nxt  = if_rdata;
      d_rdata_nxt   = d_rdata;
      if_ack_nxt    = 1'b0;
      d_ack_nxt     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (pick_d) begin
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = d_we;
               mem_addr_nxt  = d_addr;
               mem_wdata_nxt = d_wdata;
               mem_be_nxt    = d_be;
               gnt_owner_nxt = OWN_D;
               state_nxt     = ST_GNT;
            end else if (pick_if) begin
               mem_req_nxt   = 1'b1;
               mem_we_nxt    = 1'b0;
               mem_addr_nxt  = if_addr;
               mem_wdata_nxt = '0;
               mem_be_nxt    = BE_FULL;
               gnt_owner_nxt = OWN_IF;
               state_nxt     = ST_GNT;
            end
         end

         ST_GNT: begin
            // mem_* hold their values until the memory completes
            if (mem_ack) begin
               mem_req_nxt = 1'b0;
               if (gnt_owner == OWN_IF) begin
                  if_ack_nxt   = 1'b1;
                  if_rdata_nxt = mem_rdata;
               end else begin
                  d_ack_nxt = 1'b1;
                  if (!mem_we)
                     d_rdata_nxt = mem_rdata;
               end
               state_nxt = ST_RESP;
            end
         end

         ST_RESP: begin
            // ack drops via its default; no arbitration in this cycle
            gnt_owner_nxt = OWN_NONE;
            state_nxt     = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst) begin
         // NOTE: the read-data holding registers are plain flops, not a
         // memory array, so they are cleared like every other output.
         state     <= ST_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         gnt_owner <= OWN_NONE;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
      end else begin
         state     <= state_nxt;
         mem_req   <= mem_req_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_be    <= mem_be_nxt;
         gnt_owner <= gnt_owner_nxt;
         if_rdata  <= if_rdata_nxt;
         d_rdata   <= d_rdata_nxt;
         if_ack    <= if_ack_nxt;
         d_ack     <= d_ack_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. The expected grant
// order of the starvation scenario depends on ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_if;
   logic        stall_mem;
   logic [1:0]  gnt_owner;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .stall_if  (stall_if),
      .stall_mem (stall_mem),
      .gnt_owner (gnt_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to 1 ns after the next rising edge (input drive point)
   task automatic drive_point();
      @(posedge clk);
      #1;
   endtask

   // advance to the next falling edge (sample point)
   task automatic sample_point();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      d_be      = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      repeat (3) sample_point();
      total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== 70'd0) begin
         bad++;
         $display("FAIL reset_mem_outputs: got req=%b we=%b addr=%h wdata=%h be=%h want all 0",
                  mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
      rst = 1'b1;
      repeat (2) sample_point();
      total++;
      if ({if_ack, d_ack, if_rdata, d_rdata} !== 66'd0) begin
         bad++;
         $display("FAIL reset_resp_outputs: got if_ack=%b d_ack=%b if_rdata=%h d_rdata=%h want all 0",
                  if_ack, d_ack, if_rdata, d_rdata);
      end
      total++;
      if ({stall_if, stall_mem, gnt_owner, mem_req} !== 5'd0) begin
         bad++;
         $display("FAIL reset_idle: got stall_if=%b stall_mem=%b owner=%b mem_req=%b want 0 0 00 0",
                  stall_if, stall_mem, gnt_owner, mem_req);
      end
   endtask

   task automatic test_fetch_single();
      drive_point();
      if_req  = 1'b1;
      if_addr = 32'h0000_0040;
      // cycle 1: request seen, not yet granted
      sample_point();
      total++;
      if (stall_if !== 1'b1 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL fetch_c1: got stall_if=%b mem_req=%b want 1 0", stall_if, mem_req);
      end
      // cycle 2: granted, memory acks in the first GNT cycle
      drive_point();
      mem_ack   = 1'b1;
      mem_rdata = 32'h8C02_0004;
      sample_point();
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 ||
          mem_be !== 4'hF || gnt_owner !== 2'b01 || stall_if !== 1'b1) begin
         bad++;
         $display("FAIL fetch_c2: got req=%b we=%b addr=%h be=%h owner=%b stall_if=%b want 1 0 00000040 f 01 1",
                  mem_req, mem_we, mem_addr, mem_be, gnt_owner, stall_if);
      end
      // cycle 3: ack pulse
      drive_point();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      sample_point();
      total++;
      if (if_ack !== 1'b1 || if_rdata !== 32'h8C02_0004 || stall_if !== 1'b0 ||
          mem_req !== 1'b0 || d_ack !== 1'b0) begin
         bad++;
         $display("FAIL fetch_c3: got if_ack=%b if_rdata=%h stall_if=%b mem_req=%b d_ack=%b want 1 8c020004 0 0 0",
                  if_ack, if_rdata, stall_if, mem_req, d_ack);
      end
      // cycle 4: back to idle, pulse gone
      drive_point();
      if_req = 1'b0;
      sample_point();
      total++;
      if (if_ack !== 1'b0 || gnt_owner !== 2'b00 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL fetch_c4: got if_ack=%b owner=%b mem_req=%b want 0 00 0",
                  if_ack, gnt_owner, mem_req);
      end
   endtask

   task automatic test_d_priority();
      drive_point();
      if_req  = 1'b1;
      if_addr = 32'h0000_0044;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0100;
      d_be    = 4'hF;
      sample_point();
      total++;
      if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin
         bad++;
         $display("FAIL prio_c1_stall: got stall_if=%b stall_mem=%b want 1 1", stall_if, stall_mem);
      end
      drive_point();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1122_3344;
      sample_point();
      total++;
      if (gnt_owner !== 2'b10 || mem_addr !== 32'h100 || mem_we !== 1'b0 || stall_if !== 1'b1) begin
         bad++;
         $display("FAIL prio_d_grant: got owner=%b addr=%h we=%b stall_if=%b want 10 00000100 0 1",
                  gnt_owner, mem_addr, mem_we, stall_if);
      end
      drive_point();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      sample_point();
      total++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h1122_3344 || if_ack !== 1'b0 || stall_if !== 1'b1) begin
         bad++;
         $display("FAIL prio_d_ack: got d_ack=%b d_rdata=%h if_ack=%b stall_if=%b want 1 11223344 0 1",
                  d_ack, d_rdata, if_ack, stall_if);
      end
      // data stage consumes its ack; IDLE cycle with only IF pending
      drive_point();
      d_req = 1'b0;
      sample_point();
      total++;
      if (gnt_owner !== 2'b00 || mem_req !== 1'b0 || d_ack !== 1'b0 || stall_if !== 1'b1) begin
         bad++;
         $display("FAIL prio_idle: got owner=%b mem_req=%b d_ack=%b stall_if=%b want 00 0 0 1",
                  gnt_owner, mem_req, d_ack, stall_if);
      end
      drive_point();
      mem_ack   = 1'b1;
      mem_rdata = 32'h5566_7788;
      sample_point();
      total++;
      if (gnt_owner !== 2'b01 || mem_addr !== 32'h44 || mem_be !== 4'hF || stall_if !== 1'b1) begin
         bad++;
         $display("FAIL prio_if_grant: got owner=%b addr=%h be=%h stall_if=%b want 01 00000044 f 1",
                  gnt_owner, mem_addr, mem_be, stall_if);
      end
      drive_point();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      sample_point();
      total++;
      if (if_ack !== 1'b1 || if_rdata !== 32'h5566_7788 || d_rdata !== 32'h1122_3344) begin
         bad++;
         $display("FAIL prio_if_ack: got if_ack=%b if_rdata=%h d_rdata=%h want 1 55667788 11223344",
                  if_ack, if_rdata, d_rdata);
      end
      drive_point();
      if_req = 1'b0;
      sample_point();
   endtask

   task automatic test_store_wait();
      drive_point();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0020;
      d_wdata = 32'hDEAD_BEEF;
      d_be    = 4'b0011;
      sample_point();
      // four GNT cycles; memory acks in the fourth
      for (int c = 0; c < 4; c++) begin
         drive_point();
         if (c == 3) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hAAAA_5555;
         end
         sample_point();
         total++;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 ||
             mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'b0011 || gnt_owner !== 2'b10 ||
             d_ack !== 1'b0) begin
            bad++;
            $display("FAIL store_gnt_%0d: got req=%b we=%b addr=%h wdata=%h be=%b owner=%b d_ack=%b want 1 1 00000020 deadbeef 0011 10 0",
                     c, mem_req, mem_we, mem_addr, mem_wdata, mem_be, gnt_owner, d_ack);
         end
      end
      drive_point();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      sample_point();
      total++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h1122_3344 || mem_req !== 1'b0 || stall_mem !== 1'b0) begin
         bad++;
         $display("FAIL store_ack: got d_ack=%b d_rdata=%h mem_req=%b stall_mem=%b want 1 11223344 0 0",
                  d_ack, d_rdata, mem_req, stall_mem);
      end
      drive_point();
      d_req = 1'b0;
      d_we  = 1'b0;
      sample_point();
      total++;
      if (d_ack !== 1'b0 || gnt_owner !== 2'b00) begin
         bad++;
         $display("FAIL store_done: got d_ack=%b owner=%b want 0 00", d_ack, gnt_owner);
      end
   endtask

   task automatic test_reset_mid_gnt();
      drive_point();
      if_req  = 1'b1;
      if_addr = 32'h0000_0080;
      sample_point();
      sample_point();
      total++;
      if (mem_req !== 1'b1 || gnt_owner !== 2'b01) begin
         bad++;
         $display("FAIL rstgnt_pre: got mem_req=%b owner=%b want 1 01", mem_req, gnt_owner);
      end
      // assert reset between edges: outputs must clear without a clock
      #2;
      rst    = 1'b0;
      if_req = 1'b0;
      #1;
      total++;
      if (mem_req !== 1'b0 || gnt_owner !== 2'b00 || mem_addr !== 32'h0 ||
          if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         bad++;
         $display("FAIL rstgnt_async: got mem_req=%b owner=%b addr=%h if_rdata=%h d_rdata=%h want 0 00 0 0 0",
                  mem_req, gnt_owner, mem_addr, if_rdata, d_rdata);
      end
      sample_point();
      rst = 1'b1;
      // late memory ack after release must be ignored
      drive_point();
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0_0BAD;
      drive_point();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      for (int c = 0; c < 3; c++) begin
         sample_point();
         total++;
         if (if_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0 ||
             gnt_owner !== 2'b00 || if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstgnt_after_%0d: got if_ack=%b d_ack=%b mem_req=%b owner=%b if_rdata=%h want 0 0 0 00 0",
                     c, if_ack, d_ack, mem_req, gnt_owner, if_rdata);
         end
      end
   endtask

   task automatic test_starvation();
      logic [1:0] exp_order [6];
`ifdef ARB_STARVE_GUARD_EN
      exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
      exp_order = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
      drive_point();
      if_req  = 1'b1;
      if_addr = 32'h0000_0200;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0300;
      d_be    = 4'hF;
      for (int g = 0; g < 6; g++) begin
         bit found = 1'b0;
         for (int c = 0; c < 10 && !found; c++) begin
            sample_point();
            if (mem_req === 1'b1)
               found = 1'b1;
         end
         total++;
         if (!found) begin
            bad++;
            $display("FAIL starve_timeout_%0d: no grant within 10 cycles", g);
            break;
         end
         if (gnt_owner !== exp_order[g]) begin
            bad++;
            $display("FAIL starve_order_%0d: got owner=%b want %b", g, gnt_owner, exp_order[g]);
         end
         drive_point();
         mem_ack = 1'b1;
         drive_point();
         mem_ack = 1'b0;
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      repeat (3) sample_point();
   endtask

   initial begin
      test_reset();
      test_fetch_single();
      test_d_priority();
      test_store_wait();
      test_reset_mid_gnt();
      test_starvation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // absolute time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
